skin_pipe_ctrl: RTL and testbench
=================================

Name: skin_pipe_ctrl

Overview:
- Sequences one frame of YCbCr pixels through the fixed-latency, non-stallable transcb/transcr transform pipelines.
- Admits a pixel only when an output slot is guaranteed, which makes downstream backpressure safe.
- Tracks in-flight pixels with a token shift register and parks results in a small first-word-fall-through (FWFT) FIFO.
- Sits between the pixel source and the skin-classification stage; emits frame start/done status.

Parameters:
- PIPE_LAT, 7, cycles from input-acceptance edge to the edge on which the pipeline result is written into the FIFO (1 ctrl register + 6 pipeline).
- FIFO_DEPTH, 8, output FIFO entries (power of 2, >= 2).
- T_W, 16, width of each transformed chroma result.
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a frame when IDLE
- in_valid  in  1  source pixel valid
- in_ready  out  1  controller accepts pixel
- in_y, in_cb, in_cr  in  8 each  source pixel
- pipe_y, pipe_cb, pipe_cr  out  8 each  registered drive to transform pipelines
- pipe_transcb, pipe_transcr  in  T_W each  pipeline results (signed)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts
- out_transcb, out_transcr  out  T_W each  FIFO head data
- out_sol, out_eof  out  1 each  head sideband: first pixel of a line / last pixel of the frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when frame fully drained

Behaviour:
- Reset (async assert, sync deassert by the user): state IDLE; all outputs 0; FIFO empty; token register, in-flight count, row/col counters 0. Pipeline data already in flight is discarded because its tokens are cleared.
- FSM states:
  - IDLE: start -> RUN; clears row/col counters.
  - RUN: accepts pixels. The accept of pixel row IMG_H-1, col IMG_W-1 -> DRAIN.
  - DRAIN: no accepts. When in-flight == 0 and FIFO empty -> IDLE with done=1 for 1 cycle.
  - start while not IDLE is ignored.
- Admission: in_ready = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH). A same-cycle FIFO pop is not credited. Accept = in_valid && in_ready at a rising edge.
- On accept: pipe_y/cb/cr <= in_*. Token bit 0 <= 1 with sol=(col==0) and eof=(last pixel); otherwise token bit 0 <= 0. pipe_* hold their value when there is no accept.
- Counters: col increments mod IMG_W; row increments on col wrap.
- Token register: PIPE_LAT stages of {valid, sol, eof}, shifting every cycle. The last stage valid writes {pipe_transcb, pipe_transcr, sol, eof} into the FIFO on that edge.
- Latency: accept edge k -> FIFO write edge k+PIPE_LAT -> out_valid high after edge k+PIPE_LAT when the FIFO was empty.
- inflight: +1 on accept, -1 on token exit; both on the same edge -> unchanged. Range 0..FIFO_DEPTH.
- FIFO push and pop on the same edge -> count unchanged, both succeed.
- Overflow is impossible by construction. A write to a full FIFO is a design error; the bench asserts on it.
- out_* are stable while out_valid && !out_ready.
- Reset mid-frame: frame abandoned, no done pulse.

Optional Feature:
- Macro: SKIN_CTRL_STALL_CNT_EN
- Defined: adds output stall_cnt [31:0]. It increments (saturating) on each RUN cycle with in_valid && !in_ready, clears on start, and resets to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset, start, IMG_W=4, IMG_H=2, in_valid=1 and out_ready=1 continuously -> in_ready never drops. 8 outputs arrive, first out_valid 7 cycles after first accept. out_sol on outputs 0 and 4, out_eof on output 7. done 1 cycle after last pop; busy falls with it.
- out_ready=0 for the whole frame, in_valid=1 -> exactly 8 accepts, then in_ready=0. The FIFO fills to 8 with no overflow. Raising out_ready drains the outputs in order with matching pipe results.
- Ramp pipe_transcb = pipe_cb + 100 (pipeline model) with in_cb=0..7 and random out_ready at 50% -> out_transcb sequence is 100..107 and each value is held while stalled.
- Steady state with FIFO at 7 entries: simultaneous push and pop -> count stays 7 and no data is lost.
- Assert rst_n low mid-frame with 3 tokens in flight -> all outputs 0 immediately. Then start a new 4x2 frame -> exactly 8 outputs, no stale data.
- Macro defined, out_ready=0, in_valid held 20 cycles after the FIFO fills -> stall_cnt = 20. start clears it to 0.

Source files
------------

// File: rtl/skin_pipe_ctrl_if.sv
// Pixel-in and result-out stream handshakes of skin_pipe_ctrl.
interface skin_pipe_ctrl_if #(
    parameter int unsigned T_W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     in_y;
    logic [7:0]     in_cb;
    logic [7:0]     in_cr;
    logic           out_valid;
    logic           out_ready;
    logic [T_W-1:0] out_transcb;
    logic [T_W-1:0] out_transcr;
    logic           out_sol;
    logic           out_eof;

    modport slave (
        input  in_valid, in_y, in_cb, in_cr,
        output in_ready,
        output out_valid, out_transcb, out_transcr, out_sol, out_eof,
        input  out_ready
    );

    modport master (
        output in_valid, in_y, in_cb, in_cr,
        input  in_ready,
        input  out_valid, out_transcb, out_transcr, out_sol, out_eof,
        output out_ready
    );
endinterface

// File: rtl/skin_pipe_ctrl.sv
// Frame sequencer for the fixed-latency transcb/transcr pipelines with credit-based admission into an FWFT FIFO.
// Defining SKIN_CTRL_STALL_CNT_EN adds the stall_cnt output.
module skin_pipe_ctrl #(
    parameter int unsigned PIPE_LAT   = 7,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned T_W        = 16,
    parameter int unsigned IMG_W      = 640,
    parameter int unsigned IMG_H      = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    skin_pipe_ctrl_if.slave       bus,
    output logic [7:0]            pipe_y,
    output logic [7:0]            pipe_cb,
    output logic [7:0]            pipe_cr,
    input  logic signed [T_W-1:0] pipe_transcb,
    input  logic signed [T_W-1:0] pipe_transcr,
    output logic                  busy,
    output logic                  done
`ifdef SKIN_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned NW = AW + 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [NW:0]   DEPTH    = (NW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [PIPE_LAT-1:0] tok_v, tok_sol, tok_eof;
    logic [NW-1:0]       inflight, fifo_count;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [T_W-1:0]      mem_cb [FIFO_DEPTH];
    logic [T_W-1:0]      mem_cr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_sol, mem_eof;
    logic in_ready, accept, last_px, push, pop, out_valid, drained, done_nx;

    // Credit check counts every token still in the pipe as an occupied slot.
    assign in_ready = (state == RUN) && (({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH);
    assign accept   = bus.in_valid && in_ready;
    assign last_px  = (row == ROW_LAST) && (col == COL_LAST);
    assign push     = tok_v[PIPE_LAT-1];
    assign out_valid = (fifo_count != '0);
    assign pop      = out_valid && bus.out_ready;
    assign drained  = (inflight == '0) && (fifo_count == '0);
    assign busy     = (state != IDLE);

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_transcb = out_valid ? mem_cb[rd_ptr] : '0;
    assign bus.out_transcr = out_valid ? mem_cr[rd_ptr] : '0;
    assign bus.out_sol     = out_valid && mem_sol[rd_ptr];
    assign bus.out_eof     = out_valid && mem_eof[rd_ptr];

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN:   if (accept && last_px) state_nx = DRAIN;
            DRAIN: if (drained) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            pipe_y   <= '0;
            pipe_cb  <= '0;
            pipe_cr  <= '0;
            tok_v    <= '0;
            tok_sol  <= '0;
            tok_eof  <= '0;
            inflight <= '0;
            fifo_count <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (state == IDLE && start) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (accept) begin
                pipe_y  <= bus.in_y;
                pipe_cb <= bus.in_cb;
                pipe_cr <= bus.in_cr;
            end
            tok_v   <= {tok_v[PIPE_LAT-2:0], accept};
            tok_sol <= {tok_sol[PIPE_LAT-2:0], accept && (col == '0)};
            tok_eof <= {tok_eof[PIPE_LAT-2:0], accept && last_px};
            case ({accept, push})
                2'b10:   inflight <= inflight + NW'(1);
                2'b01:   inflight <= inflight - NW'(1);
                default: inflight <= inflight;
            endcase
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + NW'(1);
                2'b01:   fifo_count <= fifo_count - NW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_cb[wr_ptr]  <= pipe_transcb;
            mem_cr[wr_ptr]  <= pipe_transcr;
            mem_sol[wr_ptr] <= tok_sol[PIPE_LAT-1];
            mem_eof[wr_ptr] <= tok_eof[PIPE_LAT-1];
        end
    end

`ifdef SKIN_CTRL_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == RUN && bus.in_valid && !in_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_skin_pipe_ctrl.sv
// Scoreboard bench for skin_pipe_ctrl: a 4x2 frame instance plus an 8x2 instance for admission and stall counting.
module tb_skin_pipe_ctrl;
    localparam int unsigned T_W = 16;
    localparam int unsigned FD  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start2 = 1'b0;
    always #5 clk = ~clk;

    skin_pipe_ctrl_if #(.T_W(T_W)) bus ();
    skin_pipe_ctrl_if #(.T_W(T_W)) bus2 ();

    logic [7:0]     pipe_y, pipe_cb, pipe_cr, p2_y, p2_cb, p2_cr;
    logic [T_W-1:0] pipe_transcb, pipe_transcr;
    logic [T_W-1:0] zero_t = '0;
    logic busy, done, busy2, done2;
`ifdef SKIN_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt, stall_cnt2;
`endif

    skin_pipe_ctrl #(.PIPE_LAT(7), .FIFO_DEPTH(FD), .T_W(T_W), .IMG_W(4), .IMG_H(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .pipe_y(pipe_y), .pipe_cb(pipe_cb), .pipe_cr(pipe_cr),
        .pipe_transcb(pipe_transcb), .pipe_transcr(pipe_transcr),
        .busy(busy), .done(done)
`ifdef SKIN_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    skin_pipe_ctrl #(.PIPE_LAT(7), .FIFO_DEPTH(FD), .T_W(T_W), .IMG_W(8), .IMG_H(2)) dut_big (
        .clk(clk), .rst_n(rst_n), .start(start2), .bus(bus2),
        .pipe_y(p2_y), .pipe_cb(p2_cb), .pipe_cr(p2_cr),
        .pipe_transcb(zero_t), .pipe_transcr(zero_t),
        .busy(busy2), .done(done2)
`ifdef SKIN_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt2)
`endif
    );

    // External transform pipeline model: 6 register stages after the pipe_* drive.
    logic [7:0] sh_cb [6];
    logic [7:0] sh_cr [6];
    always @(posedge clk) begin
        sh_cb[0] <= pipe_cb;
        sh_cr[0] <= pipe_cr;
        for (int i = 1; i < 6; i++) begin
            sh_cb[i] <= sh_cb[i-1];
            sh_cr[i] <= sh_cr[i-1];
        end
    end
    assign pipe_transcb = 16'(sh_cb[5]) + 16'd100;
    assign pipe_transcr = 16'(sh_cr[5]) - 16'd128;

    logic [7:0]  cr_tab     [8] = '{8'd200, 8'd197, 8'd194, 8'd191, 8'd188, 8'd185, 8'd182, 8'd179};
    logic [15:0] exp_cr_tab [8] = '{16'd72, 16'd69, 16'd66, 16'd63, 16'd60, 16'd57, 16'd54, 16'd51};

    typedef struct packed {
        logic [15:0] cb;
        logic [15:0] cr;
        logic        sol;
        logic        eof;
    } res_t;

    res_t q[$];
    res_t held, head, expv;
    bit   hold_v = 0;
    int   errors = 0, checks = 0;
    int   cyc = 0;
    int unsigned cur_base = 0, pix = 0, acc_cnt = 0, pops = 0, done_cnt = 0;
    int   first_acc_edge = -1, first_out_edge = -1, last_pop_edge = 0, done_edge = 0;
    logic busy_at_done = 1'b1;
    int unsigned acc2 = 0, done2_cnt = 0;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard push on accept, pop/compare on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            acc_cnt = 0;
            hold_v  = 0;
        end else begin
            if (start && !busy) begin
                acc_cnt = 0;
                pops = 0;
                first_acc_edge = -1;
                first_out_edge = -1;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (acc_cnt == 0) first_acc_edge = cyc + 1;
                expv.cb  = 16'(cur_base + acc_cnt + 100);
                expv.cr  = exp_cr_tab[acc_cnt % 8];
                expv.sol = (acc_cnt % 4 == 0);
                expv.eof = (acc_cnt == 7);
                q.push_back(expv);
                acc_cnt++;
            end
            head = {bus.out_transcb, bus.out_transcr, bus.out_sol, bus.out_eof};
            if (hold_v) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", head, held);
            end
            if (bus.out_valid && first_out_edge < 0) first_out_edge = cyc;
            hold_v = bus.out_valid && !bus.out_ready;
            held = head;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    expv = q.pop_front();
                    chk("out_transcb", head.cb, expv.cb);
                    chk("out_transcr", head.cr, expv.cr);
                    chk("out_sol", head.sol, expv.sol);
                    chk("out_eof", head.eof, expv.eof);
                end
                pops++;
                last_pop_edge = cyc + 1;
            end
            if (done) begin
                done_cnt++;
                done_edge = cyc;
                busy_at_done = busy;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && dut.push)
            chk("fifo_no_overflow", (dut.fifo_count == FD) && !(bus.out_valid && bus.out_ready), 0);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            acc2 = 0;
        end else begin
            if (start2 && !busy2) acc2 = 0;
            if (bus2.in_valid && bus2.in_ready) acc2++;
            if (done2) done2_cnt++;
        end
    end

    task automatic drive_px();
        bus.in_y  = 8'(pix);
        bus.in_cb = 8'(cur_base + pix);
        bus.in_cr = cr_tab[pix % 8];
    endtask

    task automatic step();
        logic acc;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            pix++;
            drive_px();
        end
        if (pix >= 8) bus.in_valid = 1'b0;
    endtask

    task automatic start_frame(int unsigned base);
        cur_base = base;
        pix = 0;
        drive_px();
        bus.in_valid = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_until_done(int unsigned mode, int unsigned budget);
        int unsigned d0 = done_cnt;
        bit ok = 0;
        for (int unsigned i = 0; i < budget; i++) begin
            if (mode == 0) bus.out_ready = 1'b1;
            else if (mode == 2) bus.out_ready = 1'($urandom_range(0, 1));
            step();
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
        chk("done_seen", ok, 1);
    endtask

    task automatic frame_checks(int unsigned frames);
        chk("out_count", pops, 8);
        chk("scoreboard_empty", q.size(), 0);
        chk("latency", first_out_edge - first_acc_edge, 7);
        chk("done_after_pop", done_edge - last_pop_edge, 1);
        chk("busy_with_done", busy_at_done, 0);
        chk("done_pulses", done_cnt, frames);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int unsigned stalls;
        bit found;
        bus.in_valid = 1'b0; bus.in_y = '0; bus.in_cb = '0; bus.in_cr = '0; bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_y = '0; bus2.in_cb = '0; bus2.in_cr = '0; bus2.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pipe_cb", pipe_cb, 0);
        chk("rst_out_transcb", bus.out_transcb, 0);
        chk("rst_out_sol", bus.out_sol, 0);
        chk("rst_out_eof", bus.out_eof, 0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // Frame 1: free flowing.
        bus.out_ready = 1'b1;
        start_frame(0);
        stalls = 0;
        for (int i = 0; i < 12 && pix < 8; i++) begin
            if (bus.in_valid && !bus.in_ready) stalls++;
            step();
        end
        chk("no_ready_drop", stalls, 0);
        run_until_done(0, 100);
        frame_checks(1);

        // Frame 2: sink blocked until the FIFO holds the whole frame.
        bus.out_ready = 1'b0;
        start_frame(16);
        for (int i = 0; i < 20; i++) step();
        chk("blocked_accepts", acc_cnt, 8);
        chk("blocked_in_ready", bus.in_ready, 0);
        chk("blocked_out_valid", bus.out_valid, 1);
        chk("blocked_fifo_count", dut.fifo_count, 8);
        chk("blocked_busy", busy, 1);
        run_until_done(0, 100);
        frame_checks(2);

        // Frame 3: cb ramp 0..7 under random backpressure.
        start_frame(0);
        run_until_done(2, 300);
        frame_checks(3);

        // Frame 4: push and pop on the same edge with 7 entries queued.
        bus.out_ready = 1'b0;
        start_frame(48);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (first_acc_edge > 0 && cyc == first_acc_edge + 13) begin
                found = 1;
                break;
            end
        end
        chk("pushpop_reached", found, 1);
        chk("pushpop_count_before", dut.fifo_count, 7);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_count_after", dut.fifo_count, 7);
        run_until_done(0, 100);
        frame_checks(4);

        // Reset with three pixels in flight, then a clean frame.
        bus.out_ready = 1'b1;
        start_frame(64);
        for (int i = 0; i < 10 && pix < 3; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pipe_cb", pipe_cb, 0);
        chk("midrst_out_transcb", bus.out_transcb, 0);
        bus.in_valid = 1'b0;
        @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt, 4);
        start_frame(96);
        run_until_done(0, 100);
        frame_checks(5);

        // Larger frame: credit limit stops admission mid-frame.
        bus2.in_valid = 1'b1;
        bus2.out_ready = 1'b0;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus2.in_ready) begin
                found = 1;
                break;
            end
        end
        chk("big_fill_seen", found, 1);
        chk("big_busy_at_fill", busy2, 1);
        repeat (20) @(posedge clk);
        #1 bus2.in_valid = 1'b0;
        @(negedge clk);
        chk("big_accepts", acc2, 8);
        chk("big_in_ready", bus2.in_ready, 0);
`ifdef SKIN_CTRL_STALL_CNT_EN
        chk("stall_cnt", stall_cnt2, 20);
`endif
        bus2.out_ready = 1'b1;
        bus2.in_valid = 1'b1;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done2_cnt != 0) begin
                found = 1;
                break;
            end
        end
        chk("big_done_seen", found, 1);
        chk("big_total_accepts", acc2, 16);
        @(posedge clk); #1 bus2.in_valid = 1'b0; start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        @(negedge clk);
        chk("big_restart_busy", busy2, 1);
`ifdef SKIN_CTRL_STALL_CNT_EN
        chk("stall_cnt_cleared", stall_cnt2, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
